tick_queue: RTL

TICK_QUEUE -- requirements
Module: tick_queue

---
 rtl/tick_queue_pkg.sv | 12 +
 rtl/tick_queue_if.sv | 31 +++
 rtl/tick_queue_wrap_ptr.sv | 23 ++
 rtl/tick_queue.sv | 94 +++++++++
 4 files changed

// File: rtl/tick_queue_pkg.sv
// Shared constants for the tick-drained queue: default data/address widths
// and the occupancy counter width, which needs one extra bit to represent "full".
package tick_queue_pkg;

  localparam int W_DEF  = 8;
  localparam int AW_DEF = 3;

  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/tick_queue_if.sv
// Producer/consumer bundle for tick_queue: write handshake, drain strobe,
// read-side pulse and status flags.
interface tick_queue_if
  import tick_queue_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
);

  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          wr_ready;
  logic          tick;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          underrun;

  modport master (
    output wr_valid, wr_data, tick,
    input  wr_ready, rd_valid, rd_data, count, full, empty, underrun
  );

  modport slave (
    input  wr_valid, wr_data, tick,
    output wr_ready, rd_valid, rd_data, count, full, empty, underrun
  );

endinterface

// File: rtl/tick_queue_wrap_ptr.sv
// AW-bit pointer that advances on en_i and wraps naturally modulo 2**AW.
module wrap_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  assign ptr_d = en_i ? ptr_q + AW'(1) : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/tick_queue.sv
// FIFO drained one entry per tick strobe. Optional sticky underrun flag is
// built only when TICK_QUEUE_UNDERRUN_EN is defined; otherwise it reads 0.
module tick_queue
  import tick_queue_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int AW = AW_DEF
) (
  input  logic      clk,
  input  logic      reset,
  tick_queue_if.slave q
);

  localparam int CW    = cnt_w(AW);
  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [W-1:0]  rd_data_q;
  logic          rd_valid_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // wr_ready is !full even on a pop cycle, so a full queue never writes through.
  assign full  = (count_q == {1'b1, {AW{1'b0}}});
  assign empty = (count_q == '0);
  assign push  = q.wr_valid && !full;
  assign pop   = q.tick && !empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  wrap_ptr #(.AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (push),
    .ptr_o (wr_ptr)
  );

  wrap_ptr #(.AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (pop),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem[rd_ptr];
    end
  end

`ifdef TICK_QUEUE_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              underrun_q <= 1'b0;
    else if (q.tick && empty) underrun_q <= 1'b1;
  end

  assign q.underrun = underrun_q;
`else
  assign q.underrun = 1'b0;
`endif

  assign q.wr_ready = !full;
  assign q.full     = full;
  assign q.empty    = empty;
  assign q.count    = count_q;
  assign q.rd_valid = rd_valid_q;
  assign q.rd_data  = rd_data_q;

endmodule
